// File: rtl/sub_bytes_serial_ctrl.sv
// ---------------------------------------------------------------------------
// sub_bytes_serial_ctrl
//
// Byte-serial AES SubBytes sequencer with concurrent error detection.
// A whole state block is captured on accept. It is then pushed one byte per
// cycle through a single S-box, a signature predictor and a signature checker.
// The substituted bytes and their per-byte error flags are reassembled into
// out_state / out_err_mask.
//
// Signature: q(y) = y[7:4] ^ y[3:0] ^ (y[7:4] & y[3:0]), a 4-bit quadratic
// fold of an S-box output byte. The predictor produces w = q(S(x)) from the
// input byte. The checker flags a byte whose (possibly corrupted) data does
// not fold to w. Optional fault injection XORs a mask into one S-box output
// before the pipe register, so the checker sees the corruption but w does not.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_state/in_valid/in_ready block input handshake (ready only in IDLE)
//   out_state/out_err_mask     substituted block and per-byte error flags
//   out_err                    OR of out_err_mask
//   out_valid/out_ready        result handshake; result held while valid
//   inj_en/inj_idx/inj_mask    fault injection, captured with the block
//   clr_cnt/err_count          saturating count of flagged bytes, sync clear
//   busy                       controller not idle
// ---------------------------------------------------------------------------
module sub_bytes_serial_ctrl #(
    parameter  int NBYTES    = 16,
    parameter  int ERR_CNT_W = 8,
    localparam int IDX_W     = $clog2(NBYTES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [8*NBYTES-1:0]   in_state,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [8*NBYTES-1:0]   out_state,
    output logic [NBYTES-1:0]     out_err_mask,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  inj_en,
    input  logic [IDX_W-1:0]      inj_idx,
    input  logic [7:0]            inj_mask,
    input  logic                  clr_cnt,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // SubBytes: multiplicative inverse (x^254, zero maps to zero) then affine map
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [3:0] quad_sig(input logic [7:0] y);
        return y[7:4] ^ y[3:0] ^ (y[7:4] & y[3:0]);
    endfunction

    // Predictor: signature of the S-box output, derived from the input byte
    function automatic logic [3:0] predict_w(input logic [7:0] x);
        return quad_sig(sbox_fwd(x));
    endfunction

    // Checker operand is {data[7:0], w[3:0]}
    function automatic logic check_err(input logic [11:0] v);
        return quad_sig(v[11:4]) != v[3:0];
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + ERR_CNT_W'(1);
    endfunction

    state_t               state_q;
    state_t               state_d;
    logic                 accept;
    logic                 last_issue;

    logic [8*NBYTES-1:0]  blk_q;
    logic                 inj_en_q;
    logic [IDX_W-1:0]     inj_idx_q;
    logic [7:0]           inj_mask_q;
    logic [IDX_W-1:0]     issue_idx_q;

    logic [7:0]           byte_p0;
    logic [7:0]           sb_p0;
    logic [3:0]           w_p0;
    logic                 inj_hit_p0;

    logic [7:0]           data_p1;
    logic [3:0]           w_p1;
    logic [IDX_W-1:0]     idx_p1;
    logic                 vld_p1;
    logic                 err_p1;

    assign accept     = in_valid && in_ready;
    assign last_issue = (issue_idx_q == IDX_W'(NBYTES - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_issue) state_d = DRAIN;
            DRAIN:                   state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
    end

    // Block and injection settings are frozen for the whole pass
    always_ff @(posedge clk) begin
        if (accept) begin
            blk_q      <= in_state;
            inj_idx_q  <= inj_idx;
            inj_mask_q <= inj_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_en_q    <= 1'b0;
            issue_idx_q <= '0;
        end else if (accept) begin
            inj_en_q    <= inj_en;
            issue_idx_q <= '0;
        end else if (state_q == RUN) begin
            issue_idx_q <= issue_idx_q + IDX_W'(1);
        end
    end

    // ---- stage p0: issue byte, S-box and predictor ----
    // An out-of-range inj_idx never equals a live index, so nothing is corrupted.
    always_comb begin
        byte_p0    = blk_q[{issue_idx_q, 3'b000} +: 8];
        sb_p0      = sbox_fwd(byte_p0);
        w_p0       = predict_w(byte_p0);
        inj_hit_p0 = inj_en_q && (inj_idx_q == issue_idx_q);
    end

    // ---- stage p1: pipe register, checker ----
    always_ff @(posedge clk) begin
        data_p1 <= inj_hit_p0 ? (sb_p0 ^ inj_mask_q) : sb_p0;
        w_p1    <= w_p0;
        idx_p1  <= issue_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= (state_q == RUN);
    end

    assign err_p1 = check_err({data_p1, w_p1});

    // ---- result write-back ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state    <= '0;
            out_err_mask <= '0;
        end else if (accept) begin
            out_err_mask <= '0;
        end else if (vld_p1) begin
            out_state[{idx_p1, 3'b000} +: 8] <= data_p1;
            out_err_mask[idx_p1]             <= err_p1;
        end
    end

    assign out_err = |out_err_mask;

    // Clear has priority over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                err_count <= '0;
        else if (clr_cnt)          err_count <= '0;
        else if (vld_p1 && err_p1) err_count <= sat_inc(err_count);
    end

endmodule

// File: tb/tb_sub_bytes_serial_ctrl.sv
module tb_sub_bytes_serial_ctrl;

    localparam int NBYTES = 16;
    localparam int IDX_W  = $clog2(NBYTES);
    localparam int LAT    = 17;   // edges after the accept edge until out_valid is seen
    localparam int PERIOD = NBYTES + 3;

    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [8*NBYTES-1:0]  in_state;
    logic                 in_valid;
    logic                 out_ready;
    logic                 inj_en;
    logic [IDX_W-1:0]     inj_idx;
    logic [7:0]           inj_mask;
    logic                 clr_cnt;

    logic                 in_ready,  b_in_ready;
    logic [8*NBYTES-1:0]  out_state, b_out_state;
    logic [NBYTES-1:0]    out_err_mask, b_out_err_mask;
    logic                 out_err,   b_out_err;
    logic                 out_valid, b_out_valid;
    logic                 busy,      b_busy;
    logic [7:0]           err_count;
    logic [1:0]           b_err_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;   // flagged bytes since last reset/clear (unsaturated)

    always #5 clk = ~clk;

    sub_bytes_serial_ctrl #(.NBYTES(NBYTES), .ERR_CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_state(in_state), .in_valid(in_valid),
        .in_ready(in_ready), .out_state(out_state), .out_err_mask(out_err_mask),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
        .inj_en(inj_en), .inj_idx(inj_idx), .inj_mask(inj_mask),
        .clr_cnt(clr_cnt), .err_count(err_count), .busy(busy)
    );

    sub_bytes_serial_ctrl #(.NBYTES(NBYTES), .ERR_CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_state(in_state), .in_valid(in_valid),
        .in_ready(b_in_ready), .out_state(b_out_state), .out_err_mask(b_out_err_mask),
        .out_err(b_out_err), .out_valid(b_out_valid), .out_ready(out_ready),
        .inj_en(inj_en), .inj_idx(inj_idx), .inj_mask(inj_mask),
        .clr_cnt(clr_cnt), .err_count(b_err_count), .busy(b_busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [127:0] row;
        row = SBOX_ROWS[x[7:4]];
        return row[8*(15 - int'(x[3:0])) +: 8];
    endfunction

    // Signature fold used by the checker, written as a plain bitwise OR
    function automatic logic [3:0] sig_ref(input logic [7:0] y);
        return y[7:4] | y[3:0];
    endfunction

    // Returns {err_mask, state} for one block
    function automatic logic [9*NBYTES-1:0] model_block(input logic [8*NBYTES-1:0] blk,
                                                        input logic ie, input int ii,
                                                        input logic [7:0] im);
        logic [8*NBYTES-1:0] st;
        logic [NBYTES-1:0]   mk;
        logic [7:0]          s;
        logic [7:0]          d;
        for (int i = 0; i < NBYTES; i++) begin
            s = sbox_ref(blk[8*i +: 8]);
            d = (ie && ii == i) ? (s ^ im) : s;
            st[8*i +: 8] = d;
            mk[i] = (sig_ref(d) != sig_ref(s));
        end
        return {mk, st};
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // ---------------- drivers ----------------
    task automatic run_block(input logic [8*NBYTES-1:0] blk, input logic ie,
                             input logic [IDX_W-1:0] ii, input logic [7:0] im,
                             input int clr_edge, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_state = blk;
        inj_en   = ie;
        inj_idx  = ii;
        inj_mask = im;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        inj_en   = 1'b0;
        lat      = 0;
        clr_cnt  = (clr_edge == 1);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            clr_cnt = (clr_edge == lat + 1);
        end
        clr_cnt = 1'b0;
    endtask

    task automatic finish_block();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [8*NBYTES-1:0] rand_block();
        logic [8*NBYTES-1:0] b;
        for (int i = 0; i < NBYTES; i++) b[8*i +: 8] = 8'($urandom_range(0, 255));
        return b;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inj_en = 1'b0;
        inj_idx = '0; inj_mask = 8'h00; clr_cnt = 1'b0; in_state = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_state !== '0) begin failures++; $display("FAIL rst_out_state got=%h exp=0", out_state); end
        checks++; if (out_err_mask !== '0) begin failures++; $display("FAIL rst_err_mask got=%h exp=0", out_err_mask); end
        checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL rst_out_err got=%b exp=0", out_err); end
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (b_err_count !== 2'd0) begin failures++; $display("FAIL rst_err_count_w2 got=%0d exp=0", b_err_count); end
        exp_cnt = 0;
    endtask

    task automatic test_known_vector();
        logic [8*NBYTES-1:0] blk;
        int lat;
        for (int i = 0; i < NBYTES; i++) blk[8*i +: 8] = 8'(i);
        run_block(blk, 1'b0, '0, 8'h00, 0, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL kv_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (out_state !== 128'h76abd7fe2b670130c56f6bf27b777c63) begin
            failures++; $display("FAIL kv_out_state got=%h exp=76abd7fe2b670130c56f6bf27b777c63", out_state); end
        checks++; if (out_err_mask !== '0) begin failures++; $display("FAIL kv_err_mask got=%h exp=0", out_err_mask); end
        checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL kv_out_err got=%b exp=0", out_err); end
        finish_block();
    endtask

    task automatic test_all_values();
        logic [7:0] perm [256];
        logic [7:0] t;
        logic [8*NBYTES-1:0] blk;
        logic [9*NBYTES-1:0] m;
        int j, lat;
        for (int i = 0; i < 256; i++) perm[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < NBYTES; i++) blk[8*i +: 8] = perm[16*b + i];
            m = model_block(blk, 1'b0, 0, 8'h00);
            run_block(blk, 1'b0, '0, 8'h00, 0, lat);
            checks++; if (out_state !== m[8*NBYTES-1:0]) begin
                failures++; $display("FAIL all_state blk=%0d got=%h exp=%h", b, out_state, m[8*NBYTES-1:0]); end
            checks++; if (out_err !== 1'b0 || out_err_mask !== '0) begin
                failures++; $display("FAIL all_err blk=%0d got=%h exp=0", b, out_err_mask); end
            checks++; if (err_count !== 8'd0) begin
                failures++; $display("FAIL all_count blk=%0d got=%0d exp=0", b, err_count); end
            finish_block();
        end
    endtask

    task automatic test_injection();
        logic [8*NBYTES-1:0] blk;
        logic [9*NBYTES-1:0] m;
        logic [IDX_W-1:0]    ii;
        int lat, masked, nflag;
        masked = 0;
        for (int x = 0; x < 256; x++) begin
            ii  = IDX_W'(x % NBYTES);
            blk = rand_block();
            blk[8*int'(ii) +: 8] = 8'(x);
            m = model_block(blk, 1'b1, int'(ii), 8'hff);
            nflag = $countones(m[9*NBYTES-1:8*NBYTES]);
            if (nflag == 0) masked++;
            exp_cnt += nflag;
            run_block(blk, 1'b1, ii, 8'hff, 0, lat);
            checks++; if (lat !== LAT) begin failures++; $display("FAIL inj_latency x=%0d got=%0d exp=%0d", x, lat, LAT); end
            checks++; if (out_state !== m[8*NBYTES-1:0]) begin
                failures++; $display("FAIL inj_state x=%0d got=%h exp=%h", x, out_state, m[8*NBYTES-1:0]); end
            checks++; if (out_err_mask !== m[9*NBYTES-1:8*NBYTES] || out_err !== (nflag != 0)) begin
                failures++; $display("FAIL inj_mask x=%0d got=%h/%b exp=%h", x, out_err_mask, out_err, m[9*NBYTES-1:8*NBYTES]); end
            checks++; if (int'(err_count) !== sat(exp_cnt, 255)) begin
                failures++; $display("FAIL inj_count x=%0d got=%0d exp=%0d", x, err_count, sat(exp_cnt, 255)); end
            checks++; if (int'(b_err_count) !== sat(exp_cnt, 3)) begin
                failures++; $display("FAIL inj_count_w2 x=%0d got=%0d exp=%0d", x, b_err_count, sat(exp_cnt, 3)); end
            finish_block();
        end
        $display("injection masked %0d of 256", masked);
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        @(negedge clk);
        in_state = rand_block();
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midrst_ctrl got valid=%b busy=%b exp=0/0", out_valid, busy); end
        checks++; if (out_state !== '0 || out_err_mask !== '0 || out_err !== 1'b0) begin
            failures++; $display("FAIL midrst_data got=%h/%h exp=0", out_state, out_err_mask); end
        checks++; if (err_count !== 8'd0 || b_err_count !== 2'd0) begin
            failures++; $display("FAIL midrst_count got=%0d/%0d exp=0", err_count, b_err_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL midrst_no_valid got=%0d exp=0", pulses); end
    endtask

    task automatic test_done_hold();
        logic [8*NBYTES-1:0] blk;
        logic [9*NBYTES-1:0] m;
        logic [IDX_W-1:0]    ii;
        logic [7:0]          im;
        int lat, bad;
        blk = rand_block();
        ii  = IDX_W'($urandom_range(0, NBYTES - 1));
        im  = 8'($urandom_range(1, 255));
        m   = model_block(blk, 1'b1, int'(ii), im);
        exp_cnt += $countones(m[9*NBYTES-1:8*NBYTES]);
        run_block(blk, 1'b1, ii, im, 0, lat);
        checks++; if (out_state !== m[8*NBYTES-1:0] || out_err_mask !== m[9*NBYTES-1:8*NBYTES]) begin
            failures++; $display("FAIL hold_result got=%h/%h exp=%h/%h", out_state, out_err_mask,
                                 m[8*NBYTES-1:0], m[9*NBYTES-1:8*NBYTES]); end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 3) begin in_state = ~blk; in_valid = 1'b1; end
            @(negedge clk);
            if (out_state !== m[8*NBYTES-1:0] || out_err_mask !== m[9*NBYTES-1:8*NBYTES]
                || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL hold_stable got=%0d bad cycles exp=0", bad); end
        in_valid = 1'b0;
        finish_block();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL hold_release got ready=%b valid=%b exp=1/0", in_ready, out_valid); end
        checks++; if (out_state !== m[8*NBYTES-1:0]) begin
            failures++; $display("FAIL hold_after got=%h exp=%h", out_state, m[8*NBYTES-1:0]); end
        checks++; if (int'(err_count) !== sat(exp_cnt, 255)) begin
            failures++; $display("FAIL hold_count got=%0d exp=%0d", err_count, sat(exp_cnt, 255)); end
    endtask

    task automatic test_back_to_back();
        logic [8*NBYTES-1:0] blk;
        logic [9*NBYTES-1:0] m;
        int acc [$];
        int cyc;
        logic seen;
        blk = rand_block();
        m   = model_block(blk, 1'b0, 0, 8'h00);
        @(negedge clk);
        in_state  = blk;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (acc.size() < 2 && cyc < 120) begin
            if (in_valid && in_ready) acc.push_back(cyc);
            if (out_valid && !seen) begin
                seen = 1'b1;
                checks++; if (out_state !== m[8*NBYTES-1:0]) begin
                    failures++; $display("FAIL b2b_state got=%h exp=%h", out_state, m[8*NBYTES-1:0]); end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (acc.size() !== 2 || acc[1] - acc[0] !== PERIOD) begin
            failures++; $display("FAIL b2b_period got=%0d accepts exp period=%0d", acc.size(), PERIOD); end
        cyc = 0;
        while (!in_ready && cyc < 60) begin @(negedge clk); cyc++; end
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_drain got=%b exp=1", in_ready); end
    endtask

    task automatic test_sat_clear();
        logic [8*NBYTES-1:0] blk;
        int lat;
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        exp_cnt = 0;
        checks++; if (err_count !== 8'd0 || b_err_count !== 2'd0) begin
            failures++; $display("FAIL clr_plain got=%0d/%0d exp=0", err_count, b_err_count); end
        // S(00)=63 folds differently from 9c, so this injection is always flagged
        for (int n = 1; n <= 4; n++) begin
            blk = rand_block();
            blk[8*3 +: 8] = 8'h00;
            run_block(blk, 1'b1, IDX_W'(3), 8'hff, 0, lat);
            exp_cnt++;
            checks++; if (int'(b_err_count) !== sat(exp_cnt, 3)) begin
                failures++; $display("FAIL sat_w2 n=%0d got=%0d exp=%0d", n, b_err_count, sat(exp_cnt, 3)); end
            checks++; if (int'(err_count) !== exp_cnt) begin
                failures++; $display("FAIL sat_w8 n=%0d got=%0d exp=%0d", n, err_count, exp_cnt); end
            finish_block();
        end
        // byte 5 is checked on the 7th edge after accept; clear lands on that edge
        blk = rand_block();
        blk[8*5 +: 8] = 8'h00;
        run_block(blk, 1'b1, IDX_W'(5), 8'hff, 7, lat);
        exp_cnt = 0;
        checks++; if (out_err_mask !== 16'h0020) begin
            failures++; $display("FAIL clr_coinc_mask got=%h exp=0020", out_err_mask); end
        checks++; if (err_count !== 8'd0 || b_err_count !== 2'd0) begin
            failures++; $display("FAIL clr_coinc_count got=%0d/%0d exp=0", err_count, b_err_count); end
        finish_block();
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_all_values();
        test_injection();
        test_reset_mid_run();
        test_done_hold();
        test_back_to_back();
        test_sat_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
